// File: rtl/fetch_queue_if.sv
// fetch_queue_if: keeps up to MAX_OUTSTANDING fetches in flight and buffers them in a QUEUE_DEPTH queue ahead of ID.
// Latency: a response is visible on out_valid the cycle after data_ok; requests stop when in-flight plus queued reaches depth.
// FETCH_STAT_EN adds stat_fetched/stat_discarded counters.
`timescale 1ns/1ps
module fetch_queue_if #(
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_flush,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_entry,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        has_exception_out,
  output logic [5:0]  ecode_out,
  output logic [8:0]  esubcode_out
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_discarded
`endif
);

  localparam int          QAW  = $clog2(QUEUE_DEPTH);
  localparam int          QPW  = QAW + 1;
  localparam int          PAW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int          PFN  = 1 << PAW;
  localparam int          OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] QD_U = QUEUE_DEPTH;
  localparam logic [31:0] MO_U = MAX_OUTSTANDING;

  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]          outstanding_q, outstanding_d;
  logic [OW-1:0]          discard_q, discard_d;
  logic                   adef_hold_q, adef_hold_d;
  logic [PAW-1:0]         pf_wptr_q, pf_wptr_d, pf_rptr_q, pf_rptr_d;
  logic [31:0]            pf_pc_q [PFN];
  logic [31:0]            pf_pc_d [PFN];
  logic [QPW-1:0]         q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
  logic [31:0]            q_pc_q [QUEUE_DEPTH];
  logic [31:0]            q_pc_d [QUEUE_DEPTH];
  logic [31:0]            q_inst_q [QUEUE_DEPTH];
  logic [31:0]            q_inst_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_exc_q, q_exc_d;

  logic           redir;
  logic [31:0]    redir_pc;
  logic [QPW-1:0] qcount, qcount_eff;
  logic           q_empty, q_full;
  logic           accept, data_drop, data_push, adef_push, q_push, q_pop;

  always_comb begin
    redir_pc = br_target;
    if (ex_flush) begin
      redir_pc = ex_entry;
    end else if (ertn_flush) begin
      redir_pc = ertn_entry;
    end
  end

  assign redir      = ex_flush | ertn_flush | br_taken;
  assign addr       = redir ? redir_pc : fetch_pc_q;
  assign qcount     = q_wptr_q - q_rptr_q;
  assign qcount_eff = redir ? '0 : qcount;
  assign q_empty    = (q_wptr_q == q_rptr_q);
  assign q_full     = (q_wptr_q[QAW] != q_rptr_q[QAW]) && (q_wptr_q[QAW-1:0] == q_rptr_q[QAW-1:0]);

  // Credit: every in-flight request must already own a queue slot, so the queue can never overflow.
  assign req = !adef_hold_q && (!br_stall || redir) && (addr[1:0] == 2'b00)
             && (32'(outstanding_q) < MO_U)
             && ((32'(outstanding_q) + 32'(qcount_eff)) < QD_U);

  assign accept    = req && addr_ok;
  assign data_drop = data_ok && (redir || (discard_q != '0));
  assign data_push = data_ok && !data_drop;
  assign adef_push = !redir && !adef_hold_q && (fetch_pc_q[1:0] != 2'b00)
                   && (outstanding_q == '0) && (discard_q == '0) && !q_full;
  assign q_push    = data_push || adef_push;
  assign q_pop     = out_valid && out_ready && !redir;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + OW'(accept) - OW'(data_ok);
    discard_d     = discard_q;
    adef_hold_d   = adef_hold_q;
    pf_wptr_d     = pf_wptr_q;
    pf_rptr_d     = pf_rptr_q;
    pf_pc_d       = pf_pc_q;
    q_wptr_d      = q_wptr_q;
    q_rptr_d      = q_rptr_q;
    q_pc_d        = q_pc_q;
    q_inst_d      = q_inst_q;
    q_exc_d       = q_exc_q;

    if (accept) begin
      fetch_pc_d         = addr + 32'd4;
      pf_pc_d[pf_wptr_q] = addr;
      pf_wptr_d          = pf_wptr_q + 1'b1;
    end else if (redir) begin
      fetch_pc_d = redir_pc;
    end
    if (data_ok) begin
      pf_rptr_d = pf_rptr_q + 1'b1;
    end

    // After a redirect every response still in flight is stale, including ones already counted.
    if (redir) begin
      discard_d   = outstanding_q - OW'(data_ok);
      adef_hold_d = 1'b0;
      q_wptr_d    = '0;
      q_rptr_d    = '0;
    end else begin
      if (data_drop) begin
        discard_d = discard_q - 1'b1;
      end
      if (adef_push) begin
        adef_hold_d = 1'b1;
      end
      if (q_push) begin
        q_pc_d[q_wptr_q[QAW-1:0]]   = data_push ? pf_pc_q[pf_rptr_q] : fetch_pc_q;
        q_inst_d[q_wptr_q[QAW-1:0]] = data_push ? rdata : 32'h0;
        q_exc_d[q_wptr_q[QAW-1:0]]  = !data_push;
        q_wptr_d                    = q_wptr_q + 1'b1;
      end
      if (q_pop) begin
        q_rptr_d = q_rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      adef_hold_q   <= 1'b0;
      pf_wptr_q     <= '0;
      pf_rptr_q     <= '0;
      pf_pc_q       <= '{default: '0};
      q_wptr_q      <= '0;
      q_rptr_q      <= '0;
      q_pc_q        <= '{default: '0};
      q_inst_q      <= '{default: '0};
      q_exc_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      adef_hold_q   <= adef_hold_d;
      pf_wptr_q     <= pf_wptr_d;
      pf_rptr_q     <= pf_rptr_d;
      pf_pc_q       <= pf_pc_d;
      q_wptr_q      <= q_wptr_d;
      q_rptr_q      <= q_rptr_d;
      q_pc_q        <= q_pc_d;
      q_inst_q      <= q_inst_d;
      q_exc_q       <= q_exc_d;
    end
  end

  assign out_valid         = !q_empty;
  assign pc_out            = q_pc_q[q_rptr_q[QAW-1:0]];
  assign inst_out          = q_inst_q[q_rptr_q[QAW-1:0]];
  assign has_exception_out = q_exc_q[q_rptr_q[QAW-1:0]];
  assign ecode_out         = has_exception_out ? 6'h8 : 6'h0;
  assign esubcode_out      = 9'h0;
  assign wr                = 1'b0;
  assign size              = 2'b10;
  assign wstrb             = 4'h0;
  assign wdata             = 32'h0;

`ifdef FETCH_STAT_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_discarded_q, stat_discarded_d;

  always_comb begin
    stat_fetched_d   = stat_fetched_q;
    stat_discarded_d = stat_discarded_q;
    if (q_push && (stat_fetched_q != 32'hffffffff)) begin
      stat_fetched_d = stat_fetched_q + 32'd1;
    end
    if (data_drop && (stat_discarded_q != 32'hffffffff)) begin
      stat_discarded_d = stat_discarded_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched_q   <= '0;
      stat_discarded_q <= '0;
    end else begin
      stat_fetched_q   <= stat_fetched_d;
      stat_discarded_q <= stat_discarded_d;
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_discarded = stat_discarded_q;
`endif

endmodule

// File: tb/tb_fetch_queue_if.sv
// Directed bench for fetch_queue_if; a one-cycle-latency in-order bus model answers accepted fetches with pc ^ KEY.
`timescale 1ns/1ps
module tb_fetch_queue_if;

  localparam logic [31:0] KEY = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_flush, ertn_flush, br_taken, br_stall;
  logic [31:0] ex_entry, ertn_entry, br_target;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        out_valid, out_ready;
  logic [31:0] pc_out, inst_out;
  logic        has_exception_out;
  logic [5:0]  ecode_out;
  logic [8:0]  esubcode_out;
`ifdef FETCH_STAT_EN
  logic [31:0] stat_fetched, stat_discarded;
`endif

  fetch_queue_if dut (
    .clk(clk), .rst(rst),
    .ex_flush(ex_flush), .ex_entry(ex_entry),
    .ertn_flush(ertn_flush), .ertn_entry(ertn_entry),
    .br_taken(br_taken), .br_target(br_target), .br_stall(br_stall),
    .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .inst_out(inst_out),
    .has_exception_out(has_exception_out), .ecode_out(ecode_out), .esubcode_out(esubcode_out)
`ifdef FETCH_STAT_EN
    , .stat_fetched(stat_fetched), .stat_discarded(stat_discarded)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  logic        resp_en;
  logic        br_fetched;
  logic [31:0] bus_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample just before the edge, then advance the bus model and drive the next response.
  task automatic tick();
    logic        acc, dok;
    logic [31:0] a, dummy;
    #1;
    acc = req && addr_ok;
    dok = data_ok;
    a   = addr;
    if (acc) n_acc++;
    if (acc && a == 32'h1c000300) br_fetched = 1'b1;
    @(posedge clk);
    #1;
    if (dok && bus_q.size() > 0) dummy = bus_q.pop_front();
    if (acc) bus_q.push_back(a);
    if (rst) bus_q.delete();
    data_ok = resp_en && (bus_q.size() > 0);
    rdata   = data_ok ? (bus_q[0] ^ KEY) : 32'h0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; addr_ok = 1'b0; resp_en = 1'b0;
    ex_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
    ex_entry = '0; ertn_entry = '0; br_target = '0;
    tick();
    tick();
    rst = 1'b0; addr_ok = 1'b1; resp_en = 1'b1; n_acc = 0;
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          seen;
    logic        found, req_seen;

    data_ok = 1'b0; rdata = '0; out_ready = 1'b1; br_fetched = 1'b0;

    // Reset state and streaming fetch
    do_reset();
    rst = 1'b1;
    tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_pc_out", pc_out, 32'h0);
    check_eq("rst_inst_out", inst_out, 32'h0);
    check_eq("rst_exc", 32'(has_exception_out), 32'd0);
    check_eq("rst_ecode", 32'(ecode_out), 32'd0);
    check_eq("rst_esub", 32'(esubcode_out), 32'd0);
    check_eq("rst_addr", addr, 32'h1c000000);
    check_eq("const_bus", {wr, size, wstrb, 25'h0}, {1'b0, 2'b10, 4'h0, 25'h0});
    check_eq("const_wdata", wdata, 32'h0);
    rst = 1'b0; addr_ok = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
    #1;
    check_eq("t1_req0", 32'(req), 32'd1);
    check_eq("t1_addr0", addr, 32'h1c000000);
    tick();
    check_eq("t1_addr1", addr, 32'h1c000004);
    check_eq("t1_valid_early", 32'(out_valid), 32'd0);
    tick();
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_pc", pc_out, 32'h1c000000);
    check_eq("t1_inst", inst_out, 32'h1c000000 ^ KEY);
    check_eq("t1_addr2", addr, 32'h1c000008);
    exp_pc = 32'h1c000000;
    seen = 0;
    for (int i = 0; i < 40 && seen < 12; i++) begin
      if (out_valid) begin
        check_eq("t1_stream_pc", pc_out, exp_pc);
        exp_pc += 32'd4;
        seen++;
      end
      tick();
    end
    check_eq("t1_stream_cnt", 32'(seen), 32'd12);

    // Credit limit with ID stalled
    do_reset();
    out_ready = 1'b0;
    repeat (8) tick();
    check_eq("t2_accepts", 32'(n_acc), 32'd4);
    check_eq("t2_req_full", 32'(req), 32'd0);
    check_eq("t2_head", pc_out, 32'h1c000000);
    out_ready = 1'b1;
    #1;
    check_eq("t2_req_pop_cycle", 32'(req), 32'd0);
    tick();
    out_ready = 1'b0;
    #1;
    check_eq("t2_req_after_pop", 32'(req), 32'd1);
    check_eq("t2_addr_after_pop", addr, 32'h1c000010);
    check_eq("t2_head_after_pop", pc_out, 32'h1c000004);

    // Branch with two stale responses in flight
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    resp_en = 1'b0;
    tick();
    tick();
    check_eq("t3_pre_valid", 32'(out_valid), 32'd1);
    br_taken = 1'b1; br_target = 32'h1c000100; resp_en = 1'b1;
    #1;
    check_eq("t3_br_addr", addr, 32'h1c000100);
    check_eq("t3_br_req", 32'(req), 32'd0);
    tick();
    br_taken = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("t3_flushed", 32'(out_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick();
    end
    check_eq("t3_valid_seen", 32'(found), 32'd1);
    check_eq("t3_pc", pc_out, 32'h1c000100);
    check_eq("t3_inst", inst_out, 32'h1c000100 ^ KEY);
`ifdef FETCH_STAT_EN
    check_eq("t3_stat_discarded", stat_discarded, 32'd2);
    check_eq("t3_stat_fetched", stat_fetched, 32'd3);
`endif

    // Exception wins over a simultaneous branch
    do_reset();
    br_fetched = 1'b0;
    ex_flush = 1'b1; ex_entry = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000300;
    #1;
    check_eq("t4_addr", addr, 32'h1c008000);
    check_eq("t4_req", 32'(req), 32'd1);
    tick();
    ex_flush = 1'b0; br_taken = 1'b0;
    tick();
    check_eq("t4_valid", 32'(out_valid), 32'd1);
    check_eq("t4_pc", pc_out, 32'h1c008000);
    repeat (5) tick();
    check_eq("t4_br_not_fetched", 32'(br_fetched), 32'd0);

    // Misaligned target raises ADEF and holds fetch until ertn
    do_reset();
    br_taken = 1'b1; br_target = 32'h1c000102;
    #1;
    check_eq("t5_req_misaligned", 32'(req), 32'd0);
    tick();
    br_taken = 1'b0;
    tick();
    check_eq("t5_valid", 32'(out_valid), 32'd1);
    check_eq("t5_pc", pc_out, 32'h1c000102);
    check_eq("t5_inst", inst_out, 32'h0);
    check_eq("t5_exc", 32'(has_exception_out), 32'd1);
    check_eq("t5_ecode", 32'(ecode_out), 32'h8);
    check_eq("t5_esub", 32'(esubcode_out), 32'd0);
    req_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req) req_seen = 1'b1;
    end
    check_eq("t5_req_held", 32'(req_seen), 32'd0);
    check_eq("t5_single_entry", 32'(out_valid), 32'd0);
    ertn_flush = 1'b1; ertn_entry = 32'h1c000200;
    tick();
    ertn_flush = 1'b0;
    #1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (req) found = 1'b1;
      else tick();
    end
    check_eq("t5_req_resume", 32'(found), 32'd1);
    check_eq("t5_addr_resume", addr, 32'h1c000200);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick();
    end
    check_eq("t5_resume_valid", 32'(found), 32'd1);
    check_eq("t5_resume_pc", pc_out, 32'h1c000200);
    check_eq("t5_resume_exc", 32'(has_exception_out), 32'd0);

    // Reset mid-operation
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    resp_en = 1'b0;
    tick();
    tick();
    check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
    check_eq("t6_pre_req", 32'(req), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; resp_en = 1'b1; out_ready = 1'b1;
    #1;
    check_eq("t6_valid", 32'(out_valid), 32'd0);
    check_eq("t6_req", 32'(req), 32'd1);
    check_eq("t6_addr", addr, 32'h1c000000);
`ifdef FETCH_STAT_EN
    check_eq("t6_stat_fetched", stat_fetched, 32'd0);
    check_eq("t6_stat_discarded", stat_discarded, 32'd0);
`endif
    tick();
    tick();
    check_eq("t6_valid_after", 32'(out_valid), 32'd1);
    check_eq("t6_pc_after", pc_out, 32'h1c000000);
    check_eq("t6_inst_after", inst_out, 32'h1c000000 ^ KEY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
